// File: rtl/outputc.sv
// Output physical-channel controller: round-robin flit arbiter, per-VC credit and
// lock tracking for the downstream input buffers, and a registered link stage.
module outputc #(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int BUFDEPTH = 4,
    parameter int PORTW    = 3,
    parameter int VCHW     = 1,
    parameter int DATAW    = 32,
    localparam int NVC     = 1 << VCHW
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             req_0,
    input  logic             req_1,
    input  logic             req_2,
    input  logic             req_3,
    input  logic             req_4,
    input  logic [PORTW-1:0] port_0,
    input  logic [PORTW-1:0] port_1,
    input  logic [PORTW-1:0] port_2,
    input  logic [PORTW-1:0] port_3,
    input  logic [PORTW-1:0] port_4,
    input  logic [VCHW-1:0]  vch_0,
    input  logic [VCHW-1:0]  vch_1,
    input  logic [VCHW-1:0]  vch_2,
    input  logic [VCHW-1:0]  vch_3,
    input  logic [VCHW-1:0]  vch_4,
    output logic             grt_0,
    output logic             grt_1,
    output logic             grt_2,
    output logic             grt_3,
    output logic             grt_4,
    input  logic [DATAW-1:0] idata,
    input  logic             ivalid,
    input  logic [VCHW-1:0]  ivch,
    input  logic [NVC-1:0]   iack,
    output logic [NVC-1:0]   ordy,
    output logic [NVC-1:0]   olck,
    output logic [DATAW-1:0] odata,
    output logic             ovalid,
    output logic [VCHW-1:0]  ovch,
    output logic             err
);

    // Flit type lives in the top three data bits; BODY (3'd2) needs no special handling.
    localparam logic [2:0]       TYPE_NONE = 3'd0;
    localparam logic [2:0]       TYPE_HEAD = 3'd1;
    localparam logic [2:0]       TYPE_TAIL = 3'd3;
    localparam logic [3:0]       DEPTH     = 4'(BUFDEPTH);
    localparam logic [PORTW-1:0] PCH       = PORTW'(PCHID);

    logic [4:0]       req_v;
    logic [4:0]       grt_v;
    logic [4:0]       elig;
    logic [PORTW-1:0] port_v [5];
    logic [VCHW-1:0]  vch_v  [5];

    logic [3:0]       credit_q [NVC];
    logic [3:0]       credit_d [NVC];
    logic [NVC-1:0]   lck_q, lck_d;
    logic [NVC-1:0]   dec_v;
    logic [2:0]       ptr_q, ptr_d;
    logic             err_q, err_d;
    logic [DATAW-1:0] odata_q;
    logic             ovalid_q;
    logic [VCHW-1:0]  ovch_q;

    logic [2:0]       ftype;
    logic             fv;
    logic             found;
    int               idx;

    assign req_v  = {req_4, req_3, req_2, req_1, req_0};
    assign port_v = '{port_0, port_1, port_2, port_3, port_4};
    assign vch_v  = '{vch_0, vch_1, vch_2, vch_3, vch_4};
    assign {grt_4, grt_3, grt_2, grt_1, grt_0} = grt_v;

    assign ftype = idata[DATAW-1:DATAW-3];
    assign fv    = ivalid && (ftype != TYPE_NONE);

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            elig[i] = req_v[i] && (port_v[i] == PCH) && (credit_q[vch_v[i]] != 4'd0);
        end
    end

    // Rotating priority: the search begins one past the last winner.
    always_comb begin
        grt_v = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= 5; k++) begin
            idx = (int'(ptr_q) + k) % 5;
            if (!found && !rst_ && elig[idx]) begin
                grt_v[idx] = 1'b1;
                ptr_d      = 3'(idx);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NVC; v++) begin
            dec_v[v] = fv && (ivch == VCHW'(v));
        end
    end

    // A simultaneous flit and credit return on the same VC cancel out.
    always_comb begin
        err_d = err_q;
        lck_d = lck_q;
        for (int v = 0; v < NVC; v++) begin
            credit_d[v] = credit_q[v];
            if (dec_v[v] && !iack[v]) begin
                if (credit_q[v] == 4'd0) err_d = 1'b1;
                else                     credit_d[v] = credit_q[v] - 4'd1;
            end else if (iack[v] && !dec_v[v]) begin
                if (credit_q[v] == DEPTH) err_d = 1'b1;
                else                      credit_d[v] = credit_q[v] + 4'd1;
            end
            if (dec_v[v]) begin
                if (ftype == TYPE_HEAD) begin
                    if (lck_q[v]) err_d = 1'b1;
                    lck_d[v] = 1'b1;
                end else if (ftype == TYPE_TAIL) begin
                    lck_d[v] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            for (int v = 0; v < NVC; v++) credit_q[v] <= DEPTH;
            lck_q    <= '0;
            ptr_q    <= '0;
            err_q    <= 1'b0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            ovch_q   <= '0;
        end else begin
            for (int v = 0; v < NVC; v++) credit_q[v] <= credit_d[v];
            lck_q    <= lck_d;
            ptr_q    <= ptr_d;
            err_q    <= err_d;
            ovalid_q <= fv;
            odata_q  <= fv ? idata : '0;
            if (fv) ovch_q <= ivch;
        end
    end

    always_comb begin
        for (int v = 0; v < NVC; v++) ordy[v] = (credit_q[v] != 4'd0);
    end

    assign olck   = lck_q;
    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign ovch   = ovch_q;
    assign err    = err_q;

endmodule

// File: tb/tb_outputc.sv
// Self-checking bench for outputc: behavioural credit/lock/arbiter model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_outputc;
  localparam int PCH = 2;
  localparam int DEPTH = 4;
  localparam int PW = 3;
  localparam int VW = 1;
  localparam int DW = 32;
  localparam int NVC = 2;
  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_HEAD = 3'd1;
  localparam logic [2:0] T_BODY = 3'd2;
  localparam logic [2:0] T_TAIL = 3'd3;
  localparam logic [2:0] T_HT   = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]    req;
  logic [PW-1:0] port [5];
  logic [VW-1:0] vch [5];
  logic [4:0]    grt;
  logic [DW-1:0] idata;
  logic          ivalid;
  logic [VW-1:0] ivch;
  logic [NVC-1:0] iack;
  logic [NVC-1:0] ordy, olck;
  logic [DW-1:0] odata;
  logic          ovalid;
  logic [VW-1:0] ovch;
  logic          err;

  outputc #(.ROUTERID(0), .PCHID(PCH), .BUFDEPTH(DEPTH), .PORTW(PW), .VCHW(VW), .DATAW(DW)) dut (
    .clk(clk), .rst_(rst_),
    .req_0(req[0]), .req_1(req[1]), .req_2(req[2]), .req_3(req[3]), .req_4(req[4]),
    .port_0(port[0]), .port_1(port[1]), .port_2(port[2]), .port_3(port[3]), .port_4(port[4]),
    .vch_0(vch[0]), .vch_1(vch[1]), .vch_2(vch[2]), .vch_3(vch[3]), .vch_4(vch[4]),
    .grt_0(grt[0]), .grt_1(grt[1]), .grt_2(grt[2]), .grt_3(grt[3]), .grt_4(grt[4]),
    .idata(idata), .ivalid(ivalid), .ivch(ivch), .iack(iack),
    .ordy(ordy), .olck(olck), .odata(odata), .ovalid(ovalid), .ovch(ovch), .err(err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: registered-visible state as of the last rising edge
  int            m_cred [NVC];
  logic [NVC-1:0] m_lck;
  int            m_ptr;
  logic          m_err;
  logic          m_ovalid;
  logic [DW-1:0] m_odata;
  logic [VW-1:0] m_ovch;
  bit            chk_en = 0;

  function automatic logic [4:0] model_grant();
    if (rst_) return 5'b0;
    for (int k = 1; k <= 5; k++) begin
      int i;
      i = (m_ptr + k) % 5;
      if (req[i] && port[i] == PW'(PCH) && m_cred[vch[i]] > 0) return 5'(1 << i);
    end
    return 5'b0;
  endfunction

  // scoreboard: compare, then advance the model with this cycle's inputs
  always @(negedge clk) begin : model_p
    logic [4:0] g;
    logic [NVC-1:0] er;
    logic fv;
    logic [2:0] ft;
    g = model_grant();
    if (chk_en) begin
      for (int v = 0; v < NVC; v++) er[v] = (m_cred[v] != 0);
      chk("grt", 64'(grt), 64'(g));
      chk("ordy", 64'(ordy), 64'(er));
      chk("olck", 64'(olck), 64'(m_lck));
      chk("ovalid", 64'(ovalid), 64'(m_ovalid));
      chk("odata", 64'(odata), 64'(m_odata));
      if (m_ovalid) chk("ovch", 64'(ovch), 64'(m_ovch));
      chk("err", 64'(err), 64'(m_err));
    end
    if (rst_) begin
      for (int v = 0; v < NVC; v++) m_cred[v] = DEPTH;
      m_lck = '0; m_ptr = 0; m_err = 0; m_ovalid = 0; m_odata = '0; m_ovch = '0;
      chk_en = 1;
    end else begin
      for (int i = 0; i < 5; i++) if (g[i]) m_ptr = i;
      ft = idata[DW-1:DW-3];
      fv = ivalid && ft != T_NONE;
      for (int v = 0; v < NVC; v++) begin
        bit dec;
        dec = fv && (int'(ivch) == v);
        if (dec && !iack[v]) begin
          if (m_cred[v] == 0) m_err = 1; else m_cred[v] = m_cred[v] - 1;
        end else if (iack[v] && !dec) begin
          if (m_cred[v] == DEPTH) m_err = 1; else m_cred[v] = m_cred[v] + 1;
        end
        if (dec && ft == T_HEAD) begin
          if (m_lck[v]) m_err = 1;
          m_lck[v] = 1;
        end
        if (dec && ft == T_TAIL) m_lck[v] = 0;
      end
      m_ovalid = fv;
      m_odata = fv ? idata : '0;
      if (fv) m_ovch = ivch;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0; ivalid = 0; idata = '0; ivch = '0; iack = '0;
    for (int i = 0; i < 5; i++) begin port[i] = '0; vch[i] = '0; end
  endtask

  task automatic do_reset(input int n);
    tick();
    rst_ = 1; idle();
    repeat (n) tick();
    rst_ = 0;
  endtask

  task automatic send(input logic [VW-1:0] vc, input logic [2:0] t, input logic [DW-1:0] pl);
    ivalid = 1; ivch = vc; idata = {t, pl[DW-4:0]};
  endtask

  localparam logic [4:0] RR_EXP [6] = '{5'b00100, 5'b10000, 5'b00001, 5'b00100, 5'b10000, 5'b00001};

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [DW-1:0] d [4];
    idle();
    // reset state
    do_reset(2);
    @(negedge clk);
    chk("rst_ordy", 64'(ordy), 64'h3);
    chk("rst_olck", 64'(olck), 64'h0);
    chk("rst_ovalid", 64'(ovalid), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_grt", 64'(grt), 64'h0);

    // round robin among inputs 0,2,4 with credits recycled every cycle
    for (int j = 0; j < 6; j++) begin
      tick();
      req = 5'b10101;
      for (int i = 0; i < 5; i++) begin port[i] = PW'(PCH); vch[i] = '0; end
      send(1'b0, T_BODY, DW'($urandom));
      iack = 2'b01;
      @(negedge clk);
      chk("rr_grant", 64'(grt), 64'(RR_EXP[j]));
    end
    tick();
    idle();
    @(negedge clk);
    chk("rr_ordy", 64'(ordy), 64'h3);

    // credit exhaustion on VC1 and resumption after one credit return
    do_reset(1);
    req = 5'b00010; port[1] = PW'(PCH); vch[1] = 1'b1;
    send(1'b1, T_BODY, DW'($urandom));
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      @(negedge clk);
      chk("vc1_grant", 64'(grt[1]), 64'h1);
    end
    tick();
    ivalid = 0;
    @(negedge clk);
    chk("vc1_empty_ordy", 64'(ordy[1]), 64'h0);
    chk("vc1_blocked", 64'(grt[1]), 64'h0);
    tick();
    iack = 2'b10;
    @(negedge clk);
    chk("vc1_ordy_lag", 64'(ordy[1]), 64'h0);
    tick();
    iack = 2'b00;
    @(negedge clk);
    chk("vc1_ordy_back", 64'(ordy[1]), 64'h1);
    chk("vc1_resume", 64'(grt[1]), 64'h1);

    // simultaneous flit and credit return at credit 2
    do_reset(1);
    send(1'b0, T_BODY, DW'($urandom));
    tick();
    tick();
    chk("model_cred2", 64'(m_cred[0]), 64'd2);
    iack = 2'b01;
    tick();
    idle();
    chk("model_cred_same", 64'(m_cred[0]), 64'd2);
    @(negedge clk);
    chk("simul_err", 64'(err), 64'h0);
    chk("simul_ordy", 64'(ordy), 64'h3);
    tick();
    send(1'b0, T_BODY, DW'($urandom));
    tick();
    tick();
    idle();
    @(negedge clk);
    chk("simul_drained", 64'(ordy), 64'h2);

    // lock tracking and link datapath
    do_reset(1);
    for (int j = 0; j < 4; j++) d[j] = {3'b000, 29'($urandom)};
    send(1'b0, T_HEAD, d[0]); iack = 2'b01;
    @(negedge clk);
    chk("lck_pre", 64'(olck), 64'h0);
    tick();
    send(1'b0, T_BODY, d[1]);
    @(negedge clk);
    chk("lck_head", 64'(olck), 64'h1);
    chk("odata_head", 64'(odata), 64'({T_HEAD, d[0][DW-4:0]}));
    tick();
    send(1'b0, T_TAIL, d[2]);
    @(negedge clk);
    chk("lck_body", 64'(olck), 64'h1);
    chk("odata_body", 64'(odata), 64'({T_BODY, d[1][DW-4:0]}));
    tick();
    send(1'b0, T_HT, d[3]);
    @(negedge clk);
    chk("lck_tail", 64'(olck), 64'h0);
    tick();
    send(1'b0, T_NONE, d[0]); iack = 2'b00;
    @(negedge clk);
    chk("lck_headtail", 64'(olck), 64'h0);
    chk("ovalid_ht", 64'(ovalid), 64'h1);
    tick();
    idle();
    @(negedge clk);
    chk("none_ovalid", 64'(ovalid), 64'h0);
    chk("none_odata", 64'(odata), 64'h0);
    chk("lock_err", 64'(err), 64'h0);

    // HEAD on a locked VC, then reset mid-packet
    do_reset(1);
    send(1'b1, T_HEAD, DW'($urandom)); iack = 2'b10;
    tick();
    send(1'b1, T_HEAD, DW'($urandom));
    tick();
    idle();
    @(negedge clk);
    chk("dbl_head_err", 64'(err), 64'h1);
    chk("dbl_head_lck", 64'(olck), 64'h2);
    do_reset(1);
    @(negedge clk);
    chk("midrst_olck", 64'(olck), 64'h0);
    chk("midrst_ordy", 64'(ordy), 64'h3);
    chk("midrst_err", 64'(err), 64'h0);
    chk("model_midrst", 64'(m_cred[1]), 64'd4);

    // credit return at full credit is sticky
    tick();
    iack = 2'b01;
    tick();
    idle();
    @(negedge clk);
    chk("over_err", 64'(err), 64'h1);
    repeat (3) tick();
    @(negedge clk);
    chk("over_sticky", 64'(err), 64'h1);

    // random traffic, occasional resets
    for (int j = 0; j < 800; j++) begin
      tick();
      rst_ = ($urandom_range(0, 79) == 0);
      req = 5'($urandom);
      for (int i = 0; i < 5; i++) begin
        port[i] = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, 4)) : PW'(PCH);
        vch[i] = VW'($urandom);
      end
      ivalid = ($urandom_range(0, 2) != 0);
      ivch = VW'($urandom);
      idata = {3'($urandom_range(0, 4)), 29'($urandom)};
      iack = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
    end
    tick();
    rst_ = 0;
    idle();
    tick();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
